// File: rtl/dendrite_cfg_loader.sv
// Loads parameter words into the daisy-chained dendrite config shift chain.
// Words arrive on a valid/ready stream, pass a 2-entry FIFO and are clocked out on a slow data clock.
module dendrite_cfg_loader #(
   parameter int unsigned WORD_LENGTH = 16,
   parameter int unsigned NUM_WORDS   = 8,
   parameter int unsigned CLK_DIV     = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               abort,
   input  logic                               wr_valid,
   output logic                               wr_ready,
   input  logic [WORD_LENGTH-1:0]             wr_data,
   output logic                               cfg_data_clk,
   output logic [WORD_LENGTH-1:0]             cfg_data,
   output logic                               busy,
   output logic                               done,
   output logic [$clog2(NUM_WORDS+1)-1:0]     word_cnt
);

   localparam int unsigned CntW = $clog2(NUM_WORDS + 1);
   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CntW-1:0] NumWordsC = CntW'(NUM_WORDS);
   localparam logic [CntW-1:0] LastWordC = CntW'(NUM_WORDS - 1);
   localparam logic [DivW-1:0] DivLastC  = DivW'(CLK_DIV - 1);

   typedef enum logic [2:0] {StIdle, StWait, StLow, StHigh, StFin} state_e;

   state_e                      state_q, state_d;
   logic [1:0][WORD_LENGTH-1:0] mem_q, mem_d;
   logic                        rd_ptr_q, rd_ptr_d;
   logic                        wr_ptr_q, wr_ptr_d;
   logic [1:0]                  fifo_cnt_q, fifo_cnt_d;
   logic [CntW-1:0]             accepted_q, accepted_d;
   logic [CntW-1:0]             word_cnt_q, word_cnt_d;
   logic [DivW-1:0]             div_q, div_d;
   logic [WORD_LENGTH-1:0]      cfg_data_q, cfg_data_d;
   logic                        cfg_data_clk_q, cfg_data_clk_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        push, pop, flush;

   assign wr_ready = busy_q && (fifo_cnt_q < 2'd2) && (accepted_q < NumWordsC) && !abort;
   assign push     = wr_valid && wr_ready;
   // No bypass: a word pushed into an empty FIFO is popped on the following cycle.
   assign pop      = (state_q == StWait) && (fifo_cnt_q != 2'd0) && !abort;
   assign flush    = ((state_q == StIdle) && start && !abort) || ((state_q != StIdle) && abort);

   always_comb begin
      state_d    = state_q;
      mem_d      = mem_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      accepted_d = accepted_q;
      word_cnt_d = word_cnt_q;
      div_d      = div_q;
      cfg_data_d = cfg_data_q;

      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = ~wr_ptr_q;
         accepted_d      = accepted_q + 1'b1;
      end
      if (pop) begin
         cfg_data_d = mem_q[rd_ptr_q];
         rd_ptr_d   = ~rd_ptr_q;
      end
      fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

      case (state_q)
         StIdle: begin
            if (start && !abort) begin
               state_d    = StWait;
               word_cnt_d = '0;
               accepted_d = '0;
            end
         end
         StWait: begin
            if (pop) begin
               state_d = StLow;
               div_d   = '0;
            end
         end
         StLow: begin
            if (div_q == DivLastC) begin
               state_d = StHigh;
               div_d   = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StHigh: begin
            if (div_q == DivLastC) begin
               word_cnt_d = word_cnt_q + 1'b1;
               state_d    = (word_cnt_q == LastWordC) ? StFin : StWait;
               div_d      = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (flush) begin
         rd_ptr_d   = 1'b0;
         wr_ptr_d   = 1'b0;
         fifo_cnt_d = 2'd0;
      end
      if ((state_q != StIdle) && abort) begin
         state_d = StIdle;
      end

      // Outputs are registered copies of the next-state decode.
      cfg_data_clk_d = (state_d == StHigh);
      busy_d         = (state_d != StIdle);
      done_d         = (state_d == StFin);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         mem_q          <= '0;
         rd_ptr_q       <= 1'b0;
         wr_ptr_q       <= 1'b0;
         fifo_cnt_q     <= 2'd0;
         accepted_q     <= '0;
         word_cnt_q     <= '0;
         div_q          <= '0;
         cfg_data_q     <= '0;
         cfg_data_clk_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         mem_q          <= mem_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         fifo_cnt_q     <= fifo_cnt_d;
         accepted_q     <= accepted_d;
         word_cnt_q     <= word_cnt_d;
         div_q          <= div_d;
         cfg_data_q     <= cfg_data_d;
         cfg_data_clk_q <= cfg_data_clk_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign cfg_data_clk = cfg_data_clk_q;
   assign cfg_data     = cfg_data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign word_cnt     = word_cnt_q;

endmodule
